pmp_scan_ctrl: RTL and testbench
================================

// Module: pmp_scan_ctrl
// PURPOSE
//  Sequential PMP checker: accepts one access request, walks PMP entries 0..NUM_ENTRIES-1 one per clock
//  through a single shared entry matcher, stops at the lowest-numbered match and returns allow/deny.
//  Sits between the LSU/fetch request path and the PMP CSR file; trades latency for one matcher instance.
// PARAMETERS
//  NUM_ENTRIES  16  number of PMP entries scanned (1..16)
//  IDX_W        4   entry index width, $clog2(NUM_ENTRIES), min 1
// PORTS
//  clk        in   1                  clock, all state updates on rising edge
//  rst        in   1                  synchronous, active-high reset
//  req_valid  in   1                  request present
//  req_ready  out  1                  block can accept (high only in IDLE)
//  req_addr   in   32                 byte address of access
//  req_size   in   2                  00 byte, 01 half, 10 word, 11 illegal
//  req_type   in   2                  access_t: 00 read, 01 write, 10 exec, 11 illegal
//  req_priv_m in   1                  access made in M-mode
//  pmp_cfg    in   8*NUM_ENTRIES      pmpcfg bytes, entry i at [8i+7:8i] = {L,00,A[1:0],X,W,R}
//  pmp_addr   in   32*NUM_ENTRIES     pmpaddr regs (addr>>2), entry i at [32i+31:32i]
//  resp_valid out  1                  result present
//  resp_ready in   1                  consumer takes result
//  resp_allow out  1                  access permitted
//  resp_hit   out  1                  an entry matched
//  resp_idx   out  IDX_W              matching entry (0 when no hit)
//  busy       out  1                  high in SCAN or RESP; CSR writes to pmp_cfg/pmp_addr stall while high
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=1, resp_valid=0, resp_allow=0, resp_hit=0, resp_idx=0, busy=0.
//  FSM IDLE -> SCAN -> RESP -> IDLE; one transaction in flight, no back-to-back overlap.
//  IDLE: req_ready=1. On req_valid&&req_ready latch addr/size/type/priv, idx<=0, go SCAN.
//   Illegal size/type or last-byte overflow: skip SCAN, go RESP with allow=0, hit=0, idx=0.
//  last = addr + (1<<size) - 1, computed 33-bit; carry out = overflow.
//  SCAN: evaluate entry idx each clock, A field of cfg selects mode:
//   OFF   no match
//   TOR   lo={pmp_addr[idx-1][29:0],2'b00} (lo=0 for idx 0), hi={pmp_addr[idx][29:0],2'b00};
//         match iff lo<=addr && last<hi; hi<=lo never matches
//   NA4   match iff addr[31:2]==pmp_addr[idx][29:0] && last[31:2]==addr[31:2]
//   NAPOT napot matcher (addr, pmp_addr[idx], size) full-containment result
//   Full containment only; partial overlap is treated as no match.
//  On match: hit=1, idx latched, go RESP. allow = (priv_m && !L) ? 1 : perm bit (R/W/X per type).
//  idx==NUM_ENTRIES-1 with no match: hit=0, idx=0, allow=priv_m, go RESP.
//  Latency: resp_valid rises k+1 clocks after accept edge on hit at entry k; NUM_ENTRIES on miss;
//   1 clock on illegal/overflow.
//  RESP: resp_* held stable while resp_valid && !resp_ready; on resp_valid&&resp_ready -> IDLE,
//   resp_valid=0 next clock; req_ready rises that same next clock (no same-cycle re-accept).
//  resp_allow/hit/idx hold last values when resp_valid=0 (not cleared), except on reset.
//  pmp_cfg/pmp_addr sampled live during SCAN; stability is guaranteed by busy-based CSR stall.
//  Reset mid-SCAN/RESP: abort, in-flight request dropped, reset values next clock.
//  req_valid during SCAN/RESP ignored (req_ready=0); requester holds it.
// STRUCTURE
//  pmp_pkg: pmp_cfg_t packed struct {L,rsvd[1:0],a_mode_t A,X,W,R}; a_mode_t enum OFF/TOR/NA4/NAPOT;
//   access_t enum READ/WRITE/EXEC; scan_state_t enum IDLE/SCAN/RESP.
//  Sub-module pmp_entry_match: combinational; mode decode, TOR/NA4 compare, wraps napot matcher;
//   inputs addr, last, size, cfg, addr_i, addr_prev; output match.
//  Top holds FSM, index counter, request/response registers, permission logic.
// TESTING
//  1 cfg0=NAPOT RW (pmp_addr0=0x0000_01FF), read 0x100 size 10 U-mode -> hit=1 idx=0 allow=1, 1 clk.
//  2 entries 0..4 OFF, entry5 TOR X-only hi=0x400 (lo from pmp_addr4=0x100), exec 0x500 size 10 U-mode
//    -> hit=1 idx=5 allow=1, latency 6; write same addr -> allow=0.
//  3 all OFF, U-mode read 0x0 -> hit=0 allow=0 after NUM_ENTRIES clks; M-mode same -> allow=1.
//  4 entry2 NA4 L=1 R=0 at 0x2000, M-mode read 0x2000 size 00 -> hit=1 idx=2 allow=0; L=0 -> allow=1.
//  5 addr=0xFFFF_FFFE size 10 -> overflow: allow=0 hit=0 after 1 clk; size 11 -> same.
//  6 hold resp_ready=0 for 5 clks (outputs stable, req_ready=0); assert rst mid-SCAN -> all reset values next clk.

Source files
------------

// File: rtl/pmp_pkg.sv
// Shared types for the sequential PMP checker: cfg byte layout, address-match modes,
// access kinds, FSM states and the NAPOT containment helper.
package pmp_pkg;

    typedef enum logic [1:0] {
        A_OFF   = 2'b00,
        A_TOR   = 2'b01,
        A_NA4   = 2'b10,
        A_NAPOT = 2'b11
    } a_mode_t;

    typedef enum logic [1:0] {
        ACC_READ  = 2'b00,
        ACC_WRITE = 2'b01,
        ACC_EXEC  = 2'b10,
        ACC_ILL   = 2'b11
    } access_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAN = 2'b01,
        ST_RESP = 2'b10
    } scan_state_t;

    typedef struct packed {
        logic       l;
        logic [1:0] rsvd;
        a_mode_t    a;
        logic       x;
        logic       w;
        logic       r;
    } pmp_cfg_t;

    // Trailing ones of pmpaddr plus the next zero form the in-region offset mask;
    // both first and last byte must land in the region for full containment.
    function automatic logic napot_match(input logic [31:0] addr,
                                         input logic [31:0] last,
                                         input logic [29:0] pa);
        logic [29:0] m;
        m = pa ^ (pa + 30'd1);
        return ((addr[31:2] & ~m) == (pa & ~m)) && ((last[31:2] & ~m) == (pa & ~m));
    endfunction

endpackage

// File: rtl/pmp_entry_match.sv
// Single shared PMP entry matcher: decodes the A field and applies TOR / NA4 / NAPOT
// full-containment checks on the byte range [addr, last].
module pmp_entry_match
    import pmp_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [31:0] last,
    input  logic [1:0]  size,
    input  pmp_cfg_t    cfg,
    input  logic [31:0] addr_i,
    input  logic [31:0] addr_prev,
    output logic        match
);

    logic [31:0] w_lo;
    logic [31:0] w_hi;
    logic        w_tor;
    logic        w_na4;
    logic        w_napot;
    logic        w_unused_ok;

    // Caller zeroes addr_prev for entry 0, giving TOR a lower bound of 0.
    assign w_lo    = {addr_prev[29:0], 2'b00};
    assign w_hi    = {addr_i[29:0], 2'b00};
    assign w_tor   = (w_hi > w_lo) && (addr >= w_lo) && (last < w_hi);
    assign w_na4   = (addr[31:2] == addr_i[29:0]) && (last[31:2] == addr[31:2]);
    assign w_napot = napot_match(addr, last, addr_i[29:0]);

    // Access size is already folded into last; permission bits are resolved by the caller.
    assign w_unused_ok = ^{size, cfg.l, cfg.rsvd, cfg.x, cfg.w, cfg.r,
                           addr_i[31:30], addr_prev[31:30]};

    always_comb begin
        match = 1'b0;
        unique case (cfg.a)
            A_TOR:   match = w_tor;
            A_NA4:   match = w_na4;
            A_NAPOT: match = w_napot;
            default: match = 1'b0;
        endcase
    end

endmodule

// File: rtl/pmp_scan_ctrl.sv
// Sequential PMP checker: accepts one request, walks entries one per clock through a
// single matcher, stops at the lowest-numbered match and reports allow/deny.
module pmp_scan_ctrl
    import pmp_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int IDX_W       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    input  logic [1:0]               req_size,
    input  logic [1:0]               req_type,
    input  logic                     req_priv_m,
    input  logic [8*NUM_ENTRIES-1:0] pmp_cfg,
    input  logic [32*NUM_ENTRIES-1:0] pmp_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic                     resp_allow,
    output logic                     resp_hit,
    output logic [IDX_W-1:0]         resp_idx,
    output logic                     busy
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    scan_state_t      r_state;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_addr;
    logic [31:0]      r_last;
    logic [1:0]       r_size;
    access_t          r_type;
    logic             r_priv_m;
    logic             r_bad;
    logic             r_allow;
    logic             r_hit;
    logic [IDX_W-1:0] r_resp_idx;

    pmp_cfg_t         w_cfg_arr  [NUM_ENTRIES];
    logic [31:0]      w_addr_arr [NUM_ENTRIES];
    pmp_cfg_t         w_cfg;
    logic [31:0]      w_addr_i;
    logic [31:0]      w_addr_prev;
    logic [IDX_W-1:0] w_prev_idx;
    logic [32:0]      w_last33;
    logic             w_bad;
    logic             w_match;
    logic             w_perm;
    logic             w_allow;

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_unpack
        assign w_cfg_arr[g]  = pmp_cfg_t'(pmp_cfg[8*g +: 8]);
        assign w_addr_arr[g] = pmp_addr[32*g +: 32];
    end

    assign w_prev_idx  = r_idx - IDX_ONE;
    assign w_cfg       = w_cfg_arr[r_idx];
    assign w_addr_i    = w_addr_arr[r_idx];
    assign w_addr_prev = (r_idx == '0) ? 32'd0 : w_addr_arr[w_prev_idx];

    // 33-bit last-byte address; a carry out means the access wraps past 4 GiB.
    assign w_last33 = {1'b0, req_addr} + (33'd1 << req_size) - 33'd1;
    assign w_bad    = (req_size == 2'b11) || (req_type == 2'b11) || w_last33[32];

    pmp_entry_match u_match (
        .addr      (r_addr),
        .last      (r_last),
        .size      (r_size),
        .cfg       (w_cfg),
        .addr_i    (w_addr_i),
        .addr_prev (w_addr_prev),
        .match     (w_match)
    );

    always_comb begin
        w_perm = 1'b0;
        unique case (r_type)
            ACC_READ:  w_perm = w_cfg.r;
            ACC_WRITE: w_perm = w_cfg.w;
            ACC_EXEC:  w_perm = w_cfg.x;
            default:   w_perm = 1'b0;
        endcase
    end

    // M-mode bypasses unlocked entries; locked entries bind M-mode too.
    assign w_allow = (r_priv_m && !w_cfg.l) ? 1'b1 : w_perm;

    // Request capture: data only, no reset needed
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && req_valid) begin
            r_addr   <= req_addr;
            r_last   <= w_last33[31:0];
            r_size   <= req_size;
            r_type   <= access_t'(req_type);
            r_priv_m <= req_priv_m;
            r_bad    <= w_bad;
        end
    end

    // Scan FSM and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_allow    <= 1'b0;
            r_hit      <= 1'b0;
            r_resp_idx <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_idx   <= '0;
                        r_state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (r_bad) begin
                        r_allow    <= 1'b0;
                        r_hit      <= 1'b0;
                        r_resp_idx <= '0;
                        r_state    <= ST_RESP;
                    end else if (w_match) begin
                        r_allow    <= w_allow;
                        r_hit      <= 1'b1;
                        r_resp_idx <= r_idx;
                        r_state    <= ST_RESP;
                    end else if (r_idx == IDX_LAST) begin
                        r_allow    <= r_priv_m;
                        r_hit      <= 1'b0;
                        r_resp_idx <= '0;
                        r_state    <= ST_RESP;
                    end else begin
                        r_idx <= r_idx + IDX_ONE;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign busy       = (r_state != ST_IDLE);
    assign resp_allow = r_allow;
    assign resp_hit   = r_hit;
    assign resp_idx   = r_resp_idx;

endmodule

// File: tb/tb_pmp_scan_ctrl.sv
// Bench for pmp_scan_ctrl: vector table driven through a scoreboard queue, plus
// hand-written response-stall and mid-scan reset sequences.
module tb_pmp_scan_ctrl;

    localparam int N  = 16;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_addr;
    logic [1:0]      req_size;
    logic [1:0]      req_type;
    logic            req_priv_m;
    logic [8*N-1:0]  pmp_cfg;
    logic [32*N-1:0] pmp_addr;
    logic            resp_valid;
    logic            resp_ready;
    logic            resp_allow;
    logic            resp_hit;
    logic [IW-1:0]   resp_idx;
    logic            busy;

    pmp_scan_ctrl #(.NUM_ENTRIES(N), .IDX_W(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_type   (req_type),
        .req_priv_m (req_priv_m),
        .pmp_cfg    (pmp_cfg),
        .pmp_addr   (pmp_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_allow (resp_allow),
        .resp_hit   (resp_hit),
        .resp_idx   (resp_idx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8*N-1:0]  cfg;
        logic [32*N-1:0] pa;
        logic [31:0]     addr;
        logic [1:0]      size;
        logic [1:0]      typ;
        logic            priv;
        logic            allow;
        logic            hit;
        logic [3:0]      idx;
        int              lat;
    } vec_t;

    typedef struct {
        logic       allow;
        logic       hit;
        logic [3:0] idx;
        int         lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic vec_t mk(input logic [31:0] addr, input logic [1:0] size,
                                input logic [1:0] typ, input logic priv,
                                input logic allow, input logic hit,
                                input logic [3:0] idx, input int lat);
        vec_t v;
        v.cfg = '0; v.pa = '0;
        v.addr = addr; v.size = size; v.typ = typ; v.priv = priv;
        v.allow = allow; v.hit = hit; v.idx = idx; v.lat = lat;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int k);
        exp_t e;
        int   lat;
        bit   got;
        @(negedge clk);
        pmp_cfg = v.cfg; pmp_addr = v.pa;
        req_addr = v.addr; req_size = v.size; req_type = v.typ; req_priv_m = v.priv;
        req_valid = 1'b1;
        e.allow = v.allow; e.hit = v.hit; e.idx = v.idx; e.lat = v.lat;
        sb.push_back(e);
        check($sformatf("v%0d req_ready", k), 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge clk); #1;
            lat++;
            if (resp_valid) got = 1'b1;
        end
        check($sformatf("v%0d resp_seen", k), 32'(got), 32'd1);
        e = sb.pop_front();
        check($sformatf("v%0d latency", k), 32'(lat), 32'(e.lat));
        check($sformatf("v%0d allow", k), 32'(resp_allow), 32'(e.allow));
        check($sformatf("v%0d hit", k), 32'(resp_hit), 32'(e.hit));
        check($sformatf("v%0d idx", k), 32'(resp_idx), 32'(e.idx));
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check($sformatf("v%0d resp_drop", k), 32'(resp_valid), 32'd0);
        check($sformatf("v%0d ready_back", k), 32'(req_ready), 32'd1);
        check($sformatf("v%0d hit_held", k), 32'(resp_hit), 32'(e.hit));
    endtask

    initial begin
        vec_t v;
        bit   got;

        // 1: NAPOT RW covering 0x000-0xFFF
        v = mk(32'h100, 2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 4'd0, 1);
        v.cfg[7:0] = 8'h1B; v.pa[31:0] = 32'h1FF; vecs.push_back(v);
        // 2: TOR X-only at entry 5, [0x400, 0x1000)
        v = mk(32'h500, 2'b10, 2'b10, 1'b0, 1'b1, 1'b1, 4'd5, 6);
        v.cfg[8*5 +: 8] = 8'h0C; v.pa[32*4 +: 32] = 32'h100; v.pa[32*5 +: 32] = 32'h400;
        vecs.push_back(v);
        v.typ = 2'b01; v.allow = 1'b0; vecs.push_back(v);
        v.priv = 1'b1; v.allow = 1'b1; vecs.push_back(v);
        v.typ = 2'b00; v.priv = 1'b0; v.addr = 32'hFFC; v.allow = 1'b0; vecs.push_back(v);
        // 3: all OFF
        vecs.push_back(mk(32'h0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 16));
        vecs.push_back(mk(32'h0, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 4'd0, 16));
        // 4: NA4 at 0x2000 on entry 2, locked R=0 then unlocked
        v = mk(32'h2000, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 4'd2, 3);
        v.cfg[8*2 +: 8] = 8'h90; v.pa[32*2 +: 32] = 32'h800; vecs.push_back(v);
        v.cfg[8*2 +: 8] = 8'h10; v.allow = 1'b1; vecs.push_back(v);
        // 5: overflow and illegal encodings
        vecs.push_back(mk(32'hFFFF_FFFE, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 4'd0, 1));
        vecs.push_back(mk(32'h100, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 4'd0, 1));
        vecs.push_back(mk(32'h100, 2'b10, 2'b11, 1'b1, 1'b0, 1'b0, 4'd0, 1));
        // partial NAPOT overlap is not a match
        v = mk(32'hFFE, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 16);
        v.cfg[7:0] = 8'h1B; v.pa[31:0] = 32'h1FF; vecs.push_back(v);
        // lowest-numbered match wins: NAPOT R on entry 1 over NA4 RWX on entry 3
        v = mk(32'h100, 2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 4'd1, 2);
        v.cfg[8*1 +: 8] = 8'h19; v.pa[32*1 +: 32] = 32'h1FF;
        v.cfg[8*3 +: 8] = 8'h17; v.pa[32*3 +: 32] = 32'h40; vecs.push_back(v);
        // TOR with hi <= lo never matches
        v = mk(32'h500, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 4'd0, 16);
        v.cfg[8*1 +: 8] = 8'h0F; v.pa[31:0] = 32'h400; v.pa[32*1 +: 32] = 32'h100;
        vecs.push_back(v);

        rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
        req_addr = '0; req_size = '0; req_type = '0; req_priv_m = 1'b0;
        pmp_cfg = '0; pmp_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst req_ready", 32'(req_ready), 32'd1);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst allow", 32'(resp_allow), 32'd0);
        check("rst hit", 32'(resp_hit), 32'd0);
        check("rst idx", 32'(resp_idx), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        rst = 1'b0;

        for (int k = 0; k < vecs.size(); k++) run_vec(vecs[k], k);

        // Response stall: outputs held, new requests ignored
        @(negedge clk);
        pmp_cfg = '0; pmp_addr = '0;
        pmp_cfg[8*3 +: 8] = 8'h1B; pmp_addr[32*3 +: 32] = 32'h1FF;
        req_addr = 32'h80; req_size = 2'b01; req_type = 2'b00; req_priv_m = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_addr = 32'h7000_0000; req_type = 2'b01;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge clk); #1;
            if (resp_valid) got = 1'b1;
        end
        check("stall resp_seen", 32'(got), 32'd1);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("stall%0d valid", c), 32'(resp_valid), 32'd1);
            check($sformatf("stall%0d req_ready", c), 32'(req_ready), 32'd0);
            check($sformatf("stall%0d busy", c), 32'(busy), 32'd1);
            check($sformatf("stall%0d allow", c), 32'(resp_allow), 32'd1);
            check($sformatf("stall%0d hit", c), 32'(resp_hit), 32'd1);
            check($sformatf("stall%0d idx", c), 32'(resp_idx), 32'd3);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("stall release valid", 32'(resp_valid), 32'd0);
        check("stall release ready", 32'(req_ready), 32'd1);

        // Reset in the middle of a scan drops the request
        @(negedge clk);
        pmp_cfg = '0; pmp_addr = '0;
        req_addr = 32'h40; req_size = 2'b10; req_type = 2'b00; req_priv_m = 1'b1;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midscan busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst req_ready", 32'(req_ready), 32'd1);
        check("midrst resp_valid", 32'(resp_valid), 32'd0);
        check("midrst allow", 32'(resp_allow), 32'd0);
        check("midrst hit", 32'(resp_hit), 32'd0);
        check("midrst idx", 32'(resp_idx), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (resp_valid) got = 1'b1;
        end
        check("midrst no late resp", 32'(got), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
